// File: rtl/moving_average_filter.sv
`default_nettype none
// ============================================================================
//  Module      : moving_average_filter
//  Description : Multi-channel boxcar averager. Per-channel history of the
//                last 2**win_log2 samples plus a running sum; outputs the
//                signed mean. Optional macro MAF_ROUND_EN selects round half
//                up instead of floor.
//  Revision    : 1.0  initial release
// ============================================================================
module moving_average_filter #(
    parameter int DATA_WIDTH = 24,
    parameter int MAX_LOG2   = 4,
    parameter int CHANNELS   = 2,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int W_W       = (MAX_LOG2 > 0) ? $clog2(MAX_LOG2 + 1) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         write,
    input  logic [CH_W-1:0]              channel,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic [W_W-1:0]               win_log2,
    output logic                         ready,
    output logic                         done,
    output logic [CH_W-1:0]              done_channel,
    output logic signed [DATA_WIDTH-1:0] data_out
);

    localparam int c_DEPTH = 1 << MAX_LOG2;
    localparam int c_TOTAL = CHANNELS * c_DEPTH;
    localparam int c_AW    = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;
    localparam int c_PW    = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
    localparam int c_ACC_W = DATA_WIDTH + MAX_LOG2;
    localparam logic [W_W-1:0]  c_MAX_WIN   = W_W'(MAX_LOG2);
    localparam logic [c_AW-1:0] c_FLUSH_END = c_AW'(c_TOTAL - 1);

    typedef enum logic [2:0] {
        S_FLUSH  = 3'd0,
        S_IDLE   = 3'd1,
        S_READ   = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [c_AW-1:0]              r_flush_cnt;
    logic [W_W-1:0]               r_active_log2;
    logic [CH_W-1:0]              r_ch;
    logic signed [DATA_WIDTH-1:0] r_data;
    logic signed [DATA_WIDTH-1:0] r_old;
    logic [CH_W-1:0]              r_done_channel;
    logic signed [DATA_WIDTH-1:0] r_data_out;

    logic signed [DATA_WIDTH-1:0] r_hist [c_TOTAL];
    logic signed [c_ACC_W-1:0]    r_acc  [CHANNELS];
    logic [c_PW-1:0]              r_ptr  [CHANNELS];

    logic [W_W-1:0]               w_win_clamped;
    logic                         w_win_match;
    logic                         w_ch_valid;
    logic                         w_flush_last;
    logic [c_PW-1:0]              w_ptr_cur;
    logic [c_PW-1:0]              w_ptr_mask;
    logic [c_AW-1:0]              w_addr;
    logic signed [c_ACC_W-1:0]    w_acc_new;
    logic signed [c_ACC_W-1:0]    w_acc_round;

    assign w_win_clamped = (win_log2 > c_MAX_WIN) ? c_MAX_WIN : win_log2;
    assign w_win_match   = (w_win_clamped == r_active_log2);
    assign w_ch_valid    = (int'(channel) < CHANNELS);
    assign w_flush_last  = (r_flush_cnt == c_FLUSH_END);

    assign w_ptr_cur  = r_ptr[r_ch];
    assign w_ptr_mask = c_PW'((32'd1 << r_active_log2) - 32'd1);
    assign w_addr     = c_AW'(int'(r_ch) * c_DEPTH + int'(w_ptr_cur));

    // Running sum: drop the oldest sample, add the newest (both sign-extended).
    assign w_acc_new = r_acc[r_ch] - c_ACC_W'(r_old) + c_ACC_W'(r_data);

`ifdef MAF_ROUND_EN
    logic signed [c_ACC_W-1:0] w_round;
    assign w_round     = (r_active_log2 != '0) ?
                         (c_ACC_W'(1) << (r_active_log2 - W_W'(1))) : '0;
    assign w_acc_round = w_acc_new + w_round;
`else
    assign w_acc_round = w_acc_new;
`endif

    assign ready        = (r_state == S_IDLE) && w_win_match;
    assign done         = (r_state == S_DONE);
    assign done_channel = r_done_channel;
    assign data_out     = r_data_out;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FLUSH:  if (w_flush_last) w_state_next = S_IDLE;
            S_IDLE: begin
                // A window change wins over a coincident write.
                if (!w_win_match)
                    w_state_next = S_FLUSH;
                else if (write && w_ch_valid)
                    w_state_next = S_READ;
            end
            S_READ:   w_state_next = S_UPDATE;
            S_UPDATE: w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_FLUSH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_FLUSH;
            r_flush_cnt    <= '0;
            r_active_log2  <= '0;
            r_ch           <= '0;
            r_data         <= '0;
            r_done_channel <= '0;
            r_data_out     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
                r_ptr[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_FLUSH: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        r_acc[i] <= '0;
                        r_ptr[i] <= '0;
                    end
                    if (w_flush_last) begin
                        r_flush_cnt   <= '0;
                        r_active_log2 <= w_win_clamped;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + c_AW'(1);
                    end
                end
                S_IDLE: begin
                    if (w_state_next == S_READ) begin
                        r_ch   <= channel;
                        r_data <= data_in;
                    end
                end
                S_UPDATE: begin
                    r_acc[r_ch]    <= w_acc_new;
                    r_ptr[r_ch]    <= (w_ptr_cur + c_PW'(1)) & w_ptr_mask;
                    r_data_out     <= DATA_WIDTH'(w_acc_round >>> r_active_log2);
                    r_done_channel <= r_ch;
                end
                default: ;
            endcase
        end
    end

    // History RAM: one synchronous read port, one write port, no reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == S_FLUSH)
                r_hist[r_flush_cnt] <= '0;
            else if (r_state == S_UPDATE)
                r_hist[w_addr] <= r_data;
        end
        if (r_state == S_READ)
            r_old <= r_hist[w_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_moving_average_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_moving_average_filter
//  Description : Scoreboard bench for moving_average_filter (24-bit, window
//                up to 8, two channels; a three-channel instance for tag checks).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_moving_average_filter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset;
    logic               write;
    logic [0:0]         channel;
    logic signed [23:0] data_in;
    logic [1:0]         win_log2;
    logic               ready, done;
    logic [0:0]         done_channel;
    logic signed [23:0] data_out;

    logic               write2;
    logic [1:0]         channel2;
    logic signed [23:0] data_in2;
    logic [1:0]         win2;
    logic               ready2, done2;
    logic [1:0]         done_channel2;
    logic signed [23:0] data_out2;

    moving_average_filter #(.DATA_WIDTH(24), .MAX_LOG2(3), .CHANNELS(2)) dut (
        .clock(clock), .reset(reset), .write(write), .channel(channel),
        .data_in(data_in), .win_log2(win_log2), .ready(ready), .done(done),
        .done_channel(done_channel), .data_out(data_out)
    );

    moving_average_filter #(.DATA_WIDTH(24), .MAX_LOG2(3), .CHANNELS(3)) dut3 (
        .clock(clock), .reset(reset), .write(write2), .channel(channel2),
        .data_in(data_in2), .win_log2(win2), .ready(ready2), .done(done2),
        .done_channel(done_channel2), .data_out(data_out2)
    );

    typedef struct {
        int     ch;
        longint val;
        int     acc_edge;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    bit   prev_done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Floor (or round-half-up) mean of a window sum.
    function automatic longint mean(input longint sum, input int k);
        longint d, num, q;
        d   = longint'(1) << k;
        num = sum;
`ifdef MAF_ROUND_EN
        if (k > 0) num = num + d / 2;
`endif
        q = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    always @(negedge clock) begin
        if (mon_en) begin
            if (done) begin
                chk("done_one_cycle", prev_done, 0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("data_out", data_out, mon_e.val);
                    chk("done_channel", done_channel, mon_e.ch);
                    chk("latency_edges", cyc + 1 - mon_e.acc_edge, 3);
                end
            end
            prev_done = done;
        end
    end

    task automatic send(input int ch, input longint d, input longint ex);
        int t;
        t = 0;
        @(negedge clock);
        while (!ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (!ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        write   = 1'b1;
        channel = ch[0:0];
        data_in = d[23:0];
        @(posedge clock);
        #1;
        sb_q.push_back('{ch: ch, val: ex, acc_edge: cyc});
        write = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
    endtask

    // Called right after the edge that enters FLUSH; counts cycles with ready low.
    task automatic measure_flush(input bit zero_out);
        int n;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (ready) break;
            n++;
            chk("done_in_flush", done, 0);
            if (zero_out) chk("data_out_in_flush", data_out, 0);
        end
        chk("flush_ready_low_cycles", n, 16);
    endtask

    task automatic change_win(input logic [1:0] w);
        @(negedge clock);
        win_log2 = w;
        #1;
        chk("ready_drop_on_win_change", ready, 0);
        @(posedge clock);
        measure_flush(1'b0);
    endtask

    initial begin
        int  t;
        bit  seen;
        longint s;
        reset    = 1'b1;
        write    = 1'b0;
        channel  = '0;
        data_in  = '0;
        win_log2 = 2'd2;
        write2   = 1'b0;
        channel2 = '0;
        data_in2 = '0;
        win2     = 2'd3;

        // Reset for one edge, then 16 flush cycles
        @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        chk("reset_done_channel", done_channel, 0);
        measure_flush(1'b1);

        // Window 4, constant 400 on ch0
        send(0, 400, 100);
        send(0, 400, 200);
        send(0, 400, 300);
        send(0, 400, 400);
        send(0, 400, 400);
        drain();

        // Window 8, interleaved channels
        change_win(2'd3);
        for (int i = 1; i <= 8; i++) begin
            send(0, 800, 100 * i);
            send(1, -800, -100 * i);
        end
        drain();

        // Window 2, negative odd values
        change_win(2'd1);
`ifdef MAF_ROUND_EN
        send(0, -3, -1);
`else
        send(0, -3, -2);
`endif
        send(0, -3, -3);
        drain();

        // Window change clears history
        change_win(2'd2);
        for (int i = 1; i <= 4; i++) send(0, 400, 100 * i);
        drain();
        change_win(2'd3);
        send(0, 800, 100);
        drain();

        // Full-scale extremes on ch1 (history cleared by the last flush)
        for (int n = 1; n <= 8; n++) begin
            s = longint'(n) * 64'sd8388607;
            send(1, 64'sd8388607, mean(s, 3));
        end
        for (int m = 1; m <= 8; m++) begin
            s = longint'(8 - m) * 64'sd8388607 - longint'(m) * 64'sd8388608;
            send(1, -64'sd8388608, mean(s, 3));
        end
        drain();
        chk("final_full_scale_neg", data_out, -8388608);

        // Three-channel instance: out-of-range tag is ignored
        t = 0;
        while (!ready2 && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk("dut3_ready", ready2, 1);
        @(negedge clock);
        write2   = 1'b1;
        channel2 = 2'd3;
        data_in2 = 24'sd1000;
        @(negedge clock);
        write2 = 1'b0;
        seen   = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (done2) seen = 1'b1;
        end
        chk("dut3_ignored_no_done", seen, 0);
        chk("dut3_ready_after_ignored", ready2, 1);
        write2   = 1'b1;
        channel2 = 2'd2;
        data_in2 = 24'sd800;
        @(negedge clock);
        write2 = 1'b0;
        seen   = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clock);
            if (done2) seen = 1'b1;
        end
        chk("dut3_valid_done", seen, 1);
        chk("dut3_data_out", data_out2, 100);
        chk("dut3_done_channel", done_channel2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
